gt_selftest_checker: RTL and testbench

- On-board stimulus/response checker for the 2-bit greater-than comparator (gt_2bit, ports a, b, agtb) on the Basys3.
- On start, drives every (a, b) operand pair into the comparator and waits a settle interval for each pair.
- Samples agtb for each pair and compares it with the expected result (a > b).
- Reports busy, done, pass, error count and the first failing vector, so the comparator is checked in hardware rather than in simulation.

---
 rtl/gt_selftest_checker.sv | 153 +++++++++++++++
 tb/tb_gt_selftest_checker.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/gt_selftest_checker.sv
// Hardware self-test for a WIDTH-bit greater-than comparator.
// Sweeps every (a, b) operand pair, holds each pair for SETTLE_CYCLES cycles,
// then samples dut_agtb and compares it with a > b. Reports the error count
// and the index of the first failing vector.
module gt_selftest_checker #(
   parameter int unsigned WIDTH         = 2,
   parameter int unsigned SETTLE_CYCLES = 4
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start,
   output logic [WIDTH-1:0]     dut_a,
   output logic [WIDTH-1:0]     dut_b,
   input  logic                 dut_agtb,
   output logic                 busy,
   output logic                 done,
   output logic                 pass,
   output logic [2*WIDTH:0]     err_count,
   output logic                 first_fail_valid,
   output logic [2*WIDTH-1:0]   first_fail_idx
);

   localparam int unsigned IW = 2 * WIDTH;
   // Counter must be at least one bit wide even when SETTLE_CYCLES = 1.
   localparam int unsigned CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

   localparam logic [CW-1:0] CNT_MAX = CW'(SETTLE_CYCLES - 1);
   localparam logic [CW-1:0] CNT_ONE = CW'(1);
   localparam logic [IW-1:0] IDX_MAX = '1;
   localparam logic [IW-1:0] IDX_ONE = IW'(1);
   localparam logic [IW:0]   ERR_ONE = (IW + 1)'(1);

   localparam logic [1:0] StIdle   = 2'd0;
   localparam logic [1:0] StSettle = 2'd1;
   localparam logic [1:0] StCheck  = 2'd2;
   localparam logic [1:0] StDone   = 2'd3;

   logic [1:0]    state_q, state_d;
   logic [IW-1:0] idx_q, idx_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [IW:0]   err_q, err_d;
   logic          ffv_q, ffv_d;
   logic [IW-1:0] ffi_q, ffi_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;
   logic          pass_q, pass_d;

   logic          exp_gt;
   logic          mismatch;

   // Expected comparator result for the vector currently driven.
   always_comb begin
      exp_gt   = idx_q[IW-1:WIDTH] > idx_q[WIDTH-1:0];
      mismatch = dut_agtb != exp_gt;
   end

   // Sweep sequencing and result accumulation.
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      cnt_d   = cnt_q;
      err_d   = err_q;
      ffv_d   = ffv_q;
      ffi_d   = ffi_q;
      busy_d  = busy_q;
      done_d  = done_q;
      pass_d  = pass_q;

      case (state_q)
         StIdle, StDone: begin
            if (start) begin
               idx_d   = '0;
               cnt_d   = '0;
               err_d   = '0;
               ffv_d   = 1'b0;
               ffi_d   = '0;
               done_d  = 1'b0;
               pass_d  = 1'b0;
               busy_d  = 1'b1;
               state_d = StSettle;
            end
         end
         StSettle: begin
            if (cnt_q == CNT_MAX) begin
               state_d = StCheck;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         StCheck: begin
            if (mismatch) begin
               err_d = err_q + ERR_ONE;
               if (!ffv_q) begin
                  ffi_d = idx_q;
                  ffv_d = 1'b1;
               end
            end
            if (idx_q == IDX_MAX) begin
               // pass must already account for the last vector's result.
               state_d = StDone;
               busy_d  = 1'b0;
               done_d  = 1'b1;
               pass_d  = (err_d == '0);
            end else begin
               idx_d   = idx_q + IDX_ONE;
               cnt_d   = '0;
               state_d = StSettle;
            end
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // State registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= StIdle;
         idx_q   <= '0;
         cnt_q   <= '0;
         err_q   <= '0;
         ffv_q   <= 1'b0;
         ffi_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         pass_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
         ffv_q   <= ffv_d;
         ffi_q   <= ffi_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         pass_q  <= pass_d;
      end
   end

   // Operands come straight from the index register, so they are glitch-free.
   always_comb begin
      dut_a            = idx_q[IW-1:WIDTH];
      dut_b            = idx_q[WIDTH-1:0];
      busy             = busy_q;
      done             = done_q;
      pass             = pass_q;
      err_count        = err_q;
      first_fail_valid = ffv_q;
      first_fail_idx   = ffi_q;
   end

endmodule

// File: tb/tb_gt_selftest_checker.sv
// Bench for gt_selftest_checker: a behavioural comparator with selectable
// faults drives dut_agtb; expected sweep results come from counting faulty
// vectors over all operand pairs.
module tb_gt_selftest_checker;

   localparam int WIDTH  = 2;
   localparam int SETTLE = 4;
   localparam int NVEC   = 1 << (2 * WIDTH);
   localparam int PER    = SETTLE + 1;
   localparam int TOTAL  = NVEC * PER;

   // Comparator personalities
   localparam int MGood   = 0;
   localparam int MStuck0 = 1;
   localparam int MStuck1 = 2;
   localparam int MInv    = 3;
   localparam int MGe     = 4;
   localparam int MRand   = 5;

   logic               clk = 1'b0;
   logic               reset = 1'b1;
   logic               start = 1'b0;
   logic [WIDTH-1:0]   dut_a;
   logic [WIDTH-1:0]   dut_b;
   logic               dut_agtb;
   logic               busy;
   logic               done;
   logic               pass;
   logic [2*WIDTH:0]   err_count;
   logic               first_fail_valid;
   logic [2*WIDTH-1:0] first_fail_idx;

   int          mode = MGood;
   logic [15:0] fault_mask = '0;

   int checks = 0;
   int errors = 0;

   int exp_err;
   int exp_ffv;
   int exp_ffi;

   gt_selftest_checker #(
      .WIDTH         (WIDTH),
      .SETTLE_CYCLES (SETTLE)
   ) dut (
      .clk              (clk),
      .reset            (reset),
      .start            (start),
      .dut_a            (dut_a),
      .dut_b            (dut_b),
      .dut_agtb         (dut_agtb),
      .busy             (busy),
      .done             (done),
      .pass             (pass),
      .err_count        (err_count),
      .first_fail_valid (first_fail_valid),
      .first_fail_idx   (first_fail_idx)
   );

   always #5 clk = ~clk;

   // Comparator under test, possibly faulty.
   function automatic logic cmp_out(input int m, input int a, input int b, input logic [15:0] msk);
      logic r;
      r = (a > b);
      case (m)
         MStuck0: r = 1'b0;
         MStuck1: r = 1'b1;
         MInv:    r = !(a > b);
         MGe:     r = (a >= b);
         MRand:   r = (a > b) ^ msk[a * 4 + b];
         default: r = (a > b);
      endcase
      return r;
   endfunction

   always_comb begin
      dut_agtb = cmp_out(mode, int'(dut_a), int'(dut_b), fault_mask);
   end

   // Expected sweep outcome: count vectors whose comparator output differs from a > b.
   task automatic compute_expect();
      exp_err = 0;
      exp_ffv = 0;
      exp_ffi = 0;
      for (int i = 0; i < NVEC; i++) begin
         int a = i / 4;
         int b = i % 4;
         if (cmp_out(mode, a, b, fault_mask) != (a > b)) begin
            if (exp_ffv == 0) exp_ffi = i;
            exp_ffv = 1;
            exp_err++;
         end
      end
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv)
      else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, ".dut_a"}, 32'(dut_a), 0);
      chk({tag, ".dut_b"}, 32'(dut_b), 0);
      chk({tag, ".busy"}, 32'(busy), 0);
      chk({tag, ".done"}, 32'(done), 0);
      chk({tag, ".pass"}, 32'(pass), 0);
      chk({tag, ".err_count"}, 32'(err_count), 0);
      chk({tag, ".ffv"}, 32'(first_fail_valid), 0);
      chk({tag, ".ffi"}, 32'(first_fail_idx), 0);
   endtask

   // Pulse start so that it is sampled by the next edge; returns #1 after that edge.
   task automatic pulse_start();
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   // Follows a sweep from the edge after start acceptance up to done,
   // optionally re-pulsing start at cycles p1/p2 (0 = none).
   task automatic run_sweep(input string tag, input int p1, input int p2);
      compute_expect();
      for (int k = 1; k <= TOTAL; k++) begin
         start = (k == p1 || k == p2);
         @(posedge clk);
         #1;
         start = 1'b0;
         if (k < TOTAL) begin
            chk({tag, ".idx"}, 32'({dut_a, dut_b}), 32'(k / PER));
            chk({tag, ".busy"}, 32'(busy), 1);
            chk({tag, ".done_early"}, 32'(done), 0);
         end
      end
      chk({tag, ".done"}, 32'(done), 1);
      chk({tag, ".busy_end"}, 32'(busy), 0);
      chk({tag, ".idx_end"}, 32'({dut_a, dut_b}), 32'(NVEC - 1));
      chk({tag, ".pass"}, 32'(pass), 32'(exp_err == 0));
      chk({tag, ".err_count"}, 32'(err_count), 32'(exp_err));
      chk({tag, ".ffv"}, 32'(first_fail_valid), 32'(exp_ffv));
      chk({tag, ".ffi"}, 32'(first_fail_idx), 32'(exp_ffi));
   endtask

   task automatic start_and_sweep(input string tag, input int m, input int p1, input int p2);
      mode = m;
      pulse_start();
      chk({tag, ".busy_first"}, 32'(busy), 1);
      chk({tag, ".done_first"}, 32'(done), 0);
      run_sweep(tag, p1, p2);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog timeout observed=running expected=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      chk_all_zero("reset");

      // Correct comparator
      start_and_sweep("good", MGood, 0, 0);
      repeat (7) @(posedge clk);
      #1;
      chk("good.done_hold", 32'(done), 1);
      chk("good.pass_hold", 32'(pass), 1);

      // Directed faulty comparators
      start_and_sweep("stuck0", MStuck0, 0, 0);
      chk("stuck0.err_const", 32'(err_count), 6);
      chk("stuck0.ffi_const", 32'(first_fail_idx), 4);
      start_and_sweep("stuck1", MStuck1, 0, 0);
      chk("stuck1.err_const", 32'(err_count), 10);
      start_and_sweep("inv", MInv, 0, 0);
      chk("inv.err_const", 32'(err_count), 16);
      start_and_sweep("ge", MGe, 0, 0);
      chk("ge.err_const", 32'(err_count), 4);

      // Restart from DONE clears results on the accepting edge
      mode = MGood;
      pulse_start();
      chk("restart.done", 32'(done), 0);
      chk("restart.busy", 32'(busy), 1);
      chk("restart.err", 32'(err_count), 0);
      chk("restart.ffv", 32'(first_fail_valid), 0);
      chk("restart.pass", 32'(pass), 0);
      run_sweep("restart", 0, 0);

      // start while busy is ignored
      start_and_sweep("repulse", MGood, 10, 50);

      // Reset mid-sweep
      mode = MStuck0;
      pulse_start();
      repeat (29) @(posedge clk);
      #1;
      chk("midreset.busy_before", 32'(busy), 1);
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      chk_all_zero("midreset");
      repeat (3) @(posedge clk);
      #1;
      chk_all_zero("midreset_idle");
      start_and_sweep("after_reset", MGood, 0, 0);

      // Reset wins over simultaneous start
      reset = 1'b1;
      start = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      start = 1'b0;
      chk_all_zero("reset_start");
      repeat (2) @(posedge clk);
      #1;
      chk("reset_start.idle", 32'(busy), 0);

      // Random fault masks with random ignored start pulses
      for (int r = 0; r < 4; r++) begin
         fault_mask = 16'($urandom);
         start_and_sweep("random", MRand, int'($urandom_range(1, TOTAL - 1)),
                         int'($urandom_range(1, TOTAL - 1)));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
